pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit_pkg.sv | 10 +
 rtl/pc_fetch_unit_npc_select.sv | 44 ++++
 rtl/pc_fetch_unit.sv | 70 +++++++
 tb/tb_pc_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: opcode/funct constants and next-PC source enum shared by fetch and decode
package pc_fetch_unit_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FUNCT_JR = 6'h08;
    typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_JMP, NPC_JR} npc_src_t;
endpackage

// File: rtl/pc_fetch_unit_npc_select.sv
// pc_fetch_unit_npc_select: combinational control-flow decode and next-PC mux
//   instruction     : fetched word; only opcode, funct and imm/target fields are used
//   pc              : current PC (word index)
//   rs_data/rt_data : register operands for branch compare and jr target
//   next_pc         : selected next PC, modulo 2^mem_size
//   is_jal          : current instruction is jal
module pc_fetch_unit_npc_select
    import pc_fetch_unit_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int mem_size = 16
) (
    input  logic [bit_size-1:0] instruction,
    input  logic [mem_size-1:0] pc,
    input  logic [bit_size-1:0] rs_data,
    input  logic [bit_size-1:0] rt_data,
    output logic [mem_size-1:0] next_pc,
    output logic                is_jal
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [mem_size-1:0] pc_inc;
    logic [bit_size-1:0] offset;
    logic                taken;
    npc_src_t            src;
    logic                unused_fields;

    assign unused_fields = &{1'b0, instruction[25:16]};

    always_comb begin
        opcode  = instruction[31:26];
        funct   = instruction[5:0];
        pc_inc  = pc + mem_size'(1);
        offset  = {{(bit_size-16){instruction[15]}}, instruction[15:0]};
        is_jal  = opcode == OP_JAL;
        taken   = (opcode == OP_BEQ && rs_data == rt_data) || (opcode == OP_BNE && rs_data != rt_data);
        src     = (opcode == OP_J || is_jal)                  ? NPC_JMP :
                  (opcode == OP_RTYPE && funct == FUNCT_JR)   ? NPC_JR  :
                  taken                                       ? NPC_BR  : NPC_SEQ;
        next_pc = src == NPC_JMP ? instruction[mem_size-1:0] :
                  src == NPC_JR  ? rs_data[mem_size-1:0]     :
                  src == NPC_BR  ? pc_inc + offset[mem_size-1:0] : pc_inc;
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, stall/halt control, jal link and retired counter
//   clk, rst            : clock, synchronous active-high reset
//   stall               : hold PC, retired and self-loop counter
//   Instruction         : word returned by IM for IM_Address
//   rs_data, rt_data    : register operands of Instruction
//   IM_Address          : current PC (word index)
//   link_addr, link_we  : jal return address and write enable for $31
//   halted              : sticky terminal self-loop flag
//   retired             : saturating committed-instruction count
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int mem_size = 16,
    parameter int halt_cnt = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [bit_size-1:0] Instruction,
    input  logic [bit_size-1:0] rs_data,
    input  logic [bit_size-1:0] rt_data,
    output logic [mem_size-1:0] IM_Address,
    output logic [bit_size-1:0] link_addr,
    output logic                link_we,
    output logic                halted,
    output logic [31:0]         retired
);
    localparam int CW = $clog2(halt_cnt + 1);

    logic [mem_size-1:0] pc;
    logic [mem_size-1:0] next_pc;
    logic [mem_size-1:0] pc_inc;
    logic                is_jal;
    logic                self_loop;
    logic [CW-1:0]       loop_cnt;

    pc_fetch_unit_npc_select #(.bit_size(bit_size), .mem_size(mem_size)) u_npc (
        .instruction(Instruction),
        .pc         (pc),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .next_pc    (next_pc),
        .is_jal     (is_jal)
    );

    assign pc_inc     = pc + mem_size'(1);
    assign self_loop  = next_pc == pc;
    assign IM_Address = pc;
    assign link_addr  = bit_size'(pc_inc);
    assign link_we    = is_jal & ~stall & ~halted;

    // The counter stops advancing once halted so it cannot wrap while parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            halted   <= 1'b0;
            retired  <= '0;
            loop_cnt <= '0;
        end else if (!stall) begin
            if (!halted) begin
                pc      <= next_pc;
                retired <= &retired ? retired : retired + 32'd1;
            end
            loop_cnt <= (self_loop && !halted) ? loop_cnt + CW'(1) : '0;
            if (self_loop && loop_cnt == CW'(halt_cnt - 1))
                halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] Instruction = NOP;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [15:0] IM_Address;
    logic [31:0] link_addr;
    logic        link_we;
    logic        halted;
    logic [31:0] retired;
    logic [31:0] r;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.bit_size(32), .mem_size(16), .halt_cnt(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .Instruction(Instruction),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .IM_Address (IM_Address),
        .link_addr  (link_addr),
        .link_we    (link_we),
        .halted     (halted),
        .retired    (retired)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [15:0] t);
        Instruction = {6'h02, 10'd0, t};
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (IM_Address !== 16'd0) $display("FAIL reset_pc: got %0d want 0", IM_Address); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
        total++; if (retired !== 32'd0) $display("FAIL reset_retired: got %0d want 0", retired); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        Instruction = NOP;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (IM_Address !== 16'(i)) $display("FAIL seq_pc: got %0d want %0d", IM_Address, i); else passed++;
            total++; if (retired !== 32'(i)) $display("FAIL seq_retired: got %0d want %0d", retired, i); else passed++;
        end
        total++; if (link_we !== 1'b0) $display("FAIL seq_link_we: got %b want 0", link_we); else passed++;
    endtask

    task automatic test_branch;
        goto(16'd5);
        Instruction = {6'h04, 10'd0, 16'hFFFD};
        rs_data = 32'd7;
        rt_data = 32'd7;
        tick();
        total++; if (IM_Address !== 16'd3) $display("FAIL beq_taken: got %0d want 3", IM_Address); else passed++;
        goto(16'd5);
        Instruction = {6'h04, 10'd0, 16'hFFFD};
        rt_data = 32'd8;
        tick();
        total++; if (IM_Address !== 16'd6) $display("FAIL beq_not_taken: got %0d want 6", IM_Address); else passed++;
        goto(16'd5);
        Instruction = {6'h05, 10'd0, 16'd4};
        rs_data = 32'd1;
        rt_data = 32'd2;
        tick();
        total++; if (IM_Address !== 16'd10) $display("FAIL bne_taken: got %0d want 10", IM_Address); else passed++;
        goto(16'd5);
        Instruction = {6'h05, 10'd0, 16'd4};
        rt_data = 32'd1;
        tick();
        total++; if (IM_Address !== 16'd6) $display("FAIL bne_not_taken: got %0d want 6", IM_Address); else passed++;
    endtask

    task automatic test_jal_jr;
        goto(16'd42);
        Instruction = {6'h03, 26'd44};
        #1;
        total++; if (link_we !== 1'b1) $display("FAIL jal_link_we: got %b want 1", link_we); else passed++;
        total++; if (link_addr !== 32'd43) $display("FAIL jal_link_addr: got %0d want 43", link_addr); else passed++;
        stall = 1'b1;
        #1;
        total++; if (link_we !== 1'b0) $display("FAIL jal_stall_link_we: got %b want 0", link_we); else passed++;
        stall = 1'b0;
        tick();
        total++; if (IM_Address !== 16'd44) $display("FAIL jal_target: got %0d want 44", IM_Address); else passed++;
        goto(16'd50);
        Instruction = 32'h0000_0008;
        rs_data = 32'h2B;
        tick();
        total++; if (IM_Address !== 16'd43) $display("FAIL jr_target: got %0d want 43", IM_Address); else passed++;
    endtask

    task automatic test_stall;
        goto(16'd20);
        Instruction = NOP;
        r = retired;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (IM_Address !== 16'd20) $display("FAIL stall_pc: got %0d want 20", IM_Address); else passed++;
            total++; if (retired !== r) $display("FAIL stall_retired: got %0d want %0d", retired, r); else passed++;
        end
        stall = 1'b0;
        tick();
        total++; if (IM_Address !== 16'd21) $display("FAIL stall_release_pc: got %0d want 21", IM_Address); else passed++;
        total++; if (retired !== r + 32'd1) $display("FAIL stall_release_retired: got %0d want %0d", retired, r + 32'd1); else passed++;
    endtask

    task automatic test_wrap;
        goto(16'hFFFF);
        Instruction = NOP;
        tick();
        total++; if (IM_Address !== 16'd0) $display("FAIL wrap_seq: got %0d want 0", IM_Address); else passed++;
        goto(16'hFFFE);
        Instruction = {6'h04, 10'd0, 16'd1};
        rs_data = 32'd0;
        rt_data = 32'd0;
        tick();
        total++; if (IM_Address !== 16'd0) $display("FAIL wrap_branch: got %0d want 0", IM_Address); else passed++;
    endtask

    task automatic test_halt;
        goto(16'd60);
        Instruction = {6'h02, 10'd0, 16'd60};
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (halted !== 1'b0) $display("FAIL halt_early: edge %0d got %b want 0", i, halted); else passed++;
        end
        tick();
        total++; if (halted !== 1'b1) $display("FAIL halt_rise: got %b want 1", halted); else passed++;
        r = retired;
        Instruction = NOP;
        tick();
        tick();
        total++; if (IM_Address !== 16'd60) $display("FAIL halt_frozen_pc: got %0d want 60", IM_Address); else passed++;
        total++; if (retired !== r) $display("FAIL halt_retired: got %0d want %0d", retired, r); else passed++;
        Instruction = {6'h03, 26'd5};
        #1;
        total++; if (link_we !== 1'b0) $display("FAIL halt_link_we: got %b want 0", link_we); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (IM_Address !== 16'd0) $display("FAIL halt_rst_pc: got %0d want 0", IM_Address); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL halt_rst_halted: got %b want 0", halted); else passed++;
    endtask

    task automatic test_halt_stall;
        goto(16'd60);
        Instruction = {6'h02, 10'd0, 16'd60};
        tick();
        tick();
        stall = 1'b1;
        tick();
        tick();
        total++; if (halted !== 1'b0) $display("FAIL halt_stall_hold: got %b want 0", halted); else passed++;
        stall = 1'b0;
        tick();
        total++; if (halted !== 1'b0) $display("FAIL halt_stall_third: got %b want 0", halted); else passed++;
        tick();
        total++; if (halted !== 1'b1) $display("FAIL halt_stall_fourth: got %b want 1", halted); else passed++;
    endtask

    task automatic test_reset_mid_branch;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        goto(16'd5);
        Instruction = {6'h04, 10'd0, 16'd9};
        rs_data = 32'd3;
        rt_data = 32'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (IM_Address !== 16'd0) $display("FAIL rst_mid_branch: got %0d want 0", IM_Address); else passed++;
        total++; if (retired !== 32'd0) $display("FAIL rst_mid_retired: got %0d want 0", retired); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal_jr();
        test_stall();
        test_wrap();
        test_halt();
        test_halt_stall();
        test_reset_mid_branch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
